// File: rtl/sa_drain.sv
// sa_drain: captures whole result matrices into a two-entry ping-pong buffer and streams them one row per beat.
// Latency: a capture pulse at cycle N presents row 0 at N+1 when empty; one row per cycle after that, no bubble between matrices.
// Backpressure: i_row_rdy low holds the current beat; a capture with both slots full and no same-cycle release is dropped and counted.
// Build option: define SA_DRAIN_TRANSPOSE_EN to stream columns instead of rows.
module sa_drain #(
  parameter int SIZE      = 4,
  parameter int O_WIDTH   = 60,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_matrix_vld,
  input  logic [O_WIDTH-1:0]      i_matrix [SIZE][SIZE],
  output logic                    o_row_vld,
  input  logic                    i_row_rdy,
  output logic [O_WIDTH-1:0]      o_row [SIZE],
  output logic [$clog2(SIZE)-1:0] o_row_idx,
  output logic                    o_row_last,
  output logic                    o_full,
  output logic                    o_drop,
  output logic [CNT_WIDTH-1:0]    o_drop_cnt
);

  localparam int IDX_W = $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e                 state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]     row_cnt_q, row_cnt_d;
  logic                 drop_q, drop_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [O_WIDTH-1:0]   mem_q [2][SIZE][SIZE];

  logic hs;
  logic rel;
  logic capture;
  logic discard;

  // Handshake, release and capture/drop decisions plus occupancy next-state.
  // wr_sel always points at the free slot unless both are full; in TWO with a
  // release it equals rd_sel, so the incoming matrix lands in the freed slot.
  always_comb begin
    hs         = full_q[rd_sel_q] & i_row_rdy;
    rel        = hs & (row_cnt_q == LAST_IDX);
    capture    = i_matrix_vld & ((state_q != TWO) | rel);
    discard    = i_matrix_vld & (state_q == TWO) & ~rel;

    state_d    = state_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    row_cnt_d  = row_cnt_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;

    if (rel) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      row_cnt_d        = '0;
    end else if (hs) begin
      row_cnt_d = row_cnt_q + IDX_W'(1);
    end

    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (discard) begin
      drop_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    unique case (state_q)
      EMPTY:   if (capture) state_d = ONE;
      ONE: begin
        if (capture && !rel)      state_d = TWO;
        else if (rel && !capture) state_d = EMPTY;
      end
      TWO:     if (rel && !capture) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Output beat: driven from the read slot, forced to zero when nothing is held.
  always_comb begin
    o_row_vld  = full_q[rd_sel_q];
    o_row_idx  = row_cnt_q;
    o_row_last = o_row_vld & (row_cnt_q == LAST_IDX);
    o_full     = &full_q;
    o_drop     = drop_q;
    o_drop_cnt = drop_cnt_q;
    for (int k = 0; k < SIZE; k++) begin
      o_row[k] = '0;
      if (o_row_vld) begin
`ifdef SA_DRAIN_TRANSPOSE_EN
        o_row[k] = mem_q[rd_sel_q][k][row_cnt_q];
`else
        o_row[k] = mem_q[rd_sel_q][row_cnt_q][k];
`endif
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      row_cnt_q  <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      row_cnt_q  <= row_cnt_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Matrix storage: written on capture only, never reset.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          mem_q[wr_sel_q][r][c] <= i_matrix[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_drain.sv
module tb_sa_drain;

  localparam int SIZE      = 4;
  localparam int O_WIDTH   = 60;
  localparam int CNT_WIDTH = 8;
  localparam int MAXCNT    = (1 << CNT_WIDTH) - 1;

  typedef logic [SIZE-1:0][O_WIDTH-1:0] row_t;
  typedef struct {
    row_t dat;
    int   idx;
    bit   last;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    i_matrix_vld = 1'b0;
  logic [O_WIDTH-1:0]      i_matrix [SIZE][SIZE];
  logic                    o_row_vld;
  logic                    i_row_rdy = 1'b0;
  logic [O_WIDTH-1:0]      o_row [SIZE];
  logic [$clog2(SIZE)-1:0] o_row_idx;
  logic                    o_row_last;
  logic                    o_full;
  logic                    o_drop;
  logic [CNT_WIDTH-1:0]    o_drop_cnt;

  sa_drain #(.SIZE(SIZE), .O_WIDTH(O_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .i_matrix_vld(i_matrix_vld), .i_matrix(i_matrix),
    .o_row_vld(o_row_vld), .i_row_rdy(i_row_rdy),
    .o_row(o_row), .o_row_idx(o_row_idx), .o_row_last(o_row_last),
    .o_full(o_full), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: matrices held, position inside the head matrix, drop count.
  logic [O_WIDTH-1:0] mat [SIZE][SIZE];
  beat_t expq[$];
  int  held     = 0;
  int  head_row = 0;
  int  drops    = 0;
  bit  post_rst = 0;

  // Per-cycle expectations handed to the monitor.
  bit  mon_en       = 0;
  bit  exp_vld      = 0;
  bit  exp_full     = 0;
  int  exp_drops    = 0;
  bit  exp_post_rst = 0;
  bit  exp_skip_row = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_matrix();
    for (int b = 0; b < SIZE; b++) begin
      beat_t e;
      for (int k = 0; k < SIZE; k++) begin
`ifdef SA_DRAIN_TRANSPOSE_EN
        e.dat[k] = mat[k][b];
`else
        e.dat[k] = mat[b][k];
`endif
      end
      e.idx  = b;
      e.last = (b == SIZE - 1);
      expq.push_back(e);
    end
  endtask

  // One clock of stimulus; updates the model for the following cycle.
  task automatic step(input bit v, input bit r, input bit rs);
    bit rel, acc;
    @(posedge clk);
    #1;
    i_matrix_vld = v;
    i_row_rdy    = r;
    rst          = rs;
    for (int a = 0; a < SIZE; a++)
      for (int c = 0; c < SIZE; c++)
        i_matrix[a][c] = mat[a][c];
    exp_vld      = (held > 0);
    exp_full     = (held == 2);
    exp_drops    = drops;
    exp_post_rst = post_rst;
    exp_skip_row = rs;
    post_rst     = 0;
    if (rs) begin
      held     = 0;
      head_row = 0;
      drops    = 0;
      post_rst = 1;
      expq.delete();
    end else begin
      rel = (held > 0) && r && (head_row == SIZE - 1);
      acc = v && ((held < 2) || rel);
      if (v && !acc && drops < MAXCNT) drops++;
      if (held > 0 && r) begin
        if (head_row == SIZE - 1) begin
          head_row = 0;
          held--;
        end else begin
          head_row++;
        end
      end
      if (acc) begin
        held++;
        push_matrix();
      end
    end
  endtask

  task automatic rand_mat();
    for (int a = 0; a < SIZE; a++)
      for (int c = 0; c < SIZE; c++)
        mat[a][c] = O_WIDTH'({$urandom(), $urandom()});
  endtask

  // Monitor: compares status every cycle and the presented beat against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("row_vld", 256'(o_row_vld), 256'(exp_vld));
        chk("full", 256'(o_full), 256'(exp_full));
        chk("drop", 256'(o_drop), 256'(exp_drops > 0));
        chk("drop_cnt", 256'(o_drop_cnt), 256'(exp_drops));
        if (exp_vld && !exp_skip_row) begin
          if (expq.size() == 0) begin
            chk("beat_expected", 256'(0), 256'(1));
          end else begin
            row_t act;
            for (int k = 0; k < SIZE; k++) act[k] = o_row[k];
            chk("row_dat", 256'(act), 256'(expq[0].dat));
            chk("row_idx", 256'(o_row_idx), 256'(expq[0].idx));
            chk("row_last", 256'(o_row_last), 256'(expq[0].last));
            if (i_row_rdy) void'(expq.pop_front());
          end
        end else if (!exp_vld) begin
          chk("idle_idx", 256'(o_row_idx), 256'(0));
          chk("idle_last", 256'(o_row_last), 256'(0));
          if (exp_post_rst) begin
            row_t act;
            for (int k = 0; k < SIZE; k++) act[k] = o_row[k];
            chk("rst_row", 256'(act), 256'(0));
          end
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < SIZE; a++)
      for (int c = 0; c < SIZE; c++) begin
        mat[a][c]      = O_WIDTH'(16 * a + c);
        i_matrix[a][c] = '0;
      end
    step(0, 0, 1);
    step(0, 0, 1);
    mon_en = 1;

    // Single matrix, 16r+c, full-rate drain.
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);

    // Alternating backpressure.
    rand_mat();
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, (i % 2) == 0, 0);

    // Three back-to-back pulses with a stalled sink: third is dropped.
    rand_mat(); step(1, 0, 0);
    rand_mat(); step(1, 0, 0);
    rand_mat(); step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);

    // Full buffer, new pulse coincident with the last-row handshake.
    rand_mat(); step(1, 0, 0);
    rand_mat(); step(1, 0, 0);
    for (int i = 0; i < SIZE - 1; i++) step(0, 1, 0);
    rand_mat(); step(1, 1, 0);
    for (int i = 0; i < 2 * SIZE + 2; i++) step(0, 1, 0);

    // Reset mid-drain at row 2, with a pulse in the reset cycle, then restart.
    rand_mat(); step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    rand_mat(); step(1, 0, 1);
    step(0, 0, 0);
    rand_mat(); step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);

    // Drop counter saturation.
    rand_mat(); step(1, 0, 0);
    rand_mat(); step(1, 0, 0);
    for (int i = 0; i < MAXCNT + 5; i++) step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    step(0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rand_mat();
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 3 * SIZE; i++) step(0, 1, 0);
    @(negedge clk);
    #1;
    chk("drain_empty", 256'(expq.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
